// File: rtl/parallel_link_ctrl.sv
// parallel_link_ctrl: byte-link controller between a valid/ready stream and a
// parallel peer. TX FIFO words are presented on curbyteout with a load strobe
// of LOAD_CYCLES clocks. Peer words captured on instrobe rising edges land in a
// first-word-fall-through RX FIFO. Overflow on RX is reported as a sticky flag.
module parallel_link_ctrl #(
  parameter int DATA_W      = 8,
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int LOAD_CYCLES = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              readytodownload,
  output logic [DATA_W-1:0] curbyteout,
  output logic              load,
  input  logic              instrobe,
  input  logic [DATA_W-1:0] curbytein,
  input  logic              ovf_clr,
  output logic [1:0]        outsignal
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [7:0]     CNT_INIT = 8'(LOAD_CYCLES - 1);
  localparam logic [TX_AW:0] TX_ONE   = {{TX_AW{1'b0}}, 1'b1};
  localparam logic [RX_AW:0] RX_ONE   = {{RX_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [DATA_W-1:0]        curbyte_q, curbyte_d;
  logic                     load_q, load_d;
  logic [1:0]               outsig_q, outsig_d;
  logic                     tx_ready_q, tx_ready_d;
  logic [TX_AW:0]           tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [RX_AW:0]           rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic                     rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0]        rx_data_q, rx_data_d;
  logic                     ovf_q, ovf_d;
  logic [SYNC_STAGES-1:0]   rdy_sync_q, rdy_sync_d;
  logic [SYNC_STAGES-1:0]   stb_sync_q, stb_sync_d;
  logic [DATA_W-1:0]        din_sync_q [SYNC_STAGES];
  logic [DATA_W-1:0]        din_sync_d [SYNC_STAGES];
  logic                     stb_dly_q, stb_dly_d;
  logic [DATA_W-1:0]        tx_mem_q [TX_DEPTH];
  logic [DATA_W-1:0]        rx_mem_q [RX_DEPTH];

  logic              rdy_s, stb_s;
  logic [DATA_W-1:0] din_s;
  logic              tx_empty, tx_push, tx_pop;
  logic              rx_full, rx_rise, rx_push, rx_pop;

  assign rdy_s    = rdy_sync_q[SYNC_STAGES-1];
  assign stb_s    = stb_sync_q[SYNC_STAGES-1];
  assign din_s    = din_sync_q[SYNC_STAGES-1];
  assign tx_empty = (tx_wr_q == tx_rd_q);
  // RX full uses pre-pop occupancy: a word arriving when full is dropped.
  assign rx_full  = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                    (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);

  // Shift the async peer inputs (and the data bus alongside) through the synchronisers.
  always_comb begin
    rdy_sync_d    = {rdy_sync_q[SYNC_STAGES-2:0], readytodownload};
    stb_sync_d    = {stb_sync_q[SYNC_STAGES-2:0], instrobe};
    din_sync_d[0] = curbytein;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      din_sync_d[i] = din_sync_q[i-1];
    end
    stb_dly_d = stb_s;
  end

  // TX FSM: pop a word when the peer is ready, then setup / strobe / hold.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    curbyte_d = curbyte_q;
    tx_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!tx_empty && rdy_s) begin
          tx_pop    = 1'b1;
          curbyte_d = tx_mem_q[tx_rd_q[TX_AW-1:0]];
          state_d   = ST_SETUP;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SETUP: begin
        cnt_d   = CNT_INIT;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d   = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    load_d = (state_d == ST_STROBE);
  end

  // FIFO pointers, RX head presentation, sticky overflow and status word.
  always_comb begin
    tx_push    = tx_valid & tx_ready_q;
    tx_wr_d    = tx_push ? (tx_wr_q + TX_ONE) : tx_wr_q;
    tx_rd_d    = tx_pop  ? (tx_rd_q + TX_ONE) : tx_rd_q;
    tx_ready_d = !((tx_wr_d[TX_AW] != tx_rd_d[TX_AW]) &&
                   (tx_wr_d[TX_AW-1:0] == tx_rd_d[TX_AW-1:0]));

    rx_rise = stb_s & ~stb_dly_q;
    rx_push = rx_rise & ~rx_full;
    rx_pop  = rx_valid_q & rx_ready;
    rx_wr_d = rx_push ? (rx_wr_q + RX_ONE) : rx_wr_q;
    rx_rd_d = rx_pop  ? (rx_rd_q + RX_ONE) : rx_rd_q;
    // The head is taken from already-written entries only, so a fresh push
    // becomes visible one clock after it lands in memory.
    rx_valid_d = (rx_wr_q != rx_rd_d);
    if (rx_valid_d) begin
      rx_data_d = rx_mem_q[rx_rd_d[RX_AW-1:0]];
    end else begin
      rx_data_d = rx_data_q;
    end

    // A set in the same cycle as a clear wins.
    if (rx_rise && rx_full) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    outsig_d = {ovf_d, (state_d != ST_IDLE)};
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_clk) begin
    if (tx_push) tx_mem_q[tx_wr_q[TX_AW-1:0]] <= tx_data;
    if (rx_push) rx_mem_q[rx_wr_q[RX_AW-1:0]] <= din_s;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      curbyte_q  <= '0;
      load_q     <= 1'b0;
      outsig_q   <= 2'b00;
      tx_ready_q <= 1'b1;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      ovf_q      <= 1'b0;
      rdy_sync_q <= '0;
      stb_sync_q <= '0;
      stb_dly_q  <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        din_sync_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      curbyte_q  <= curbyte_d;
      load_q     <= load_d;
      outsig_q   <= outsig_d;
      tx_ready_q <= tx_ready_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      ovf_q      <= ovf_d;
      rdy_sync_q <= rdy_sync_d;
      stb_sync_q <= stb_sync_d;
      stb_dly_q  <= stb_dly_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        din_sync_q[i] <= din_sync_d[i];
      end
    end
  end

  assign tx_ready   = tx_ready_q;
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign curbyteout = curbyte_q;
  assign load       = load_q;
  assign outsignal  = outsig_q;

endmodule

// File: tb/tb_parallel_link_ctrl.sv
// Bench for parallel_link_ctrl: table-driven TX/RX vectors feeding scoreboards,
// plus hand-written sequences for flow control, overflow and reset.
module tb_parallel_link_ctrl;

  localparam int SYNC  = 2;
  localparam int LOADC = 4;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rdy;
  logic [7:0] curbyteout;
  logic       load;
  logic       instrobe;
  logic [7:0] curbytein;
  logic       ovf_clr;
  logic [1:0] outsignal;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int load_rises = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  parallel_link_ctrl #(
    .DATA_W(8), .TX_DEPTH(16), .RX_DEPTH(16), .LOAD_CYCLES(LOADC), .SYNC_STAGES(SYNC)
  ) dut (
    .clk_clk(clk), .reset_reset(rst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .readytodownload(rdy), .curbyteout(curbyteout), .load(load),
    .instrobe(instrobe), .curbytein(curbytein), .ovf_clr(ovf_clr),
    .outsignal(outsignal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] w, input logic [7:0] e);
    tx_data  = w;
    tx_valid = 1'b1;
    if (tx_ready) tx_exp.push_back(e);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] w, input bit store, input bit clr);
    curbytein = w;
    instrobe  = 1'b1;
    if (store) rx_exp.push_back(w);
    for (int i = 0; i < SYNC; i++) tick();
    ovf_clr = clr;
    tick();
    ovf_clr = 1'b0;
    tick();
    instrobe = 1'b0;
    repeat (4) tick();
  endtask

  task automatic wait_tx_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((tx_exp.size() != 0 || outsignal[0] !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_rx_empty(input int budget, input string name);
    int n;
    n = 0;
    while (rx_exp.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_load(input int budget, input string name);
    int n;
    n = 0;
    while (load !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  // Output monitor: strobe width/gap/stability and both scoreboards.
  initial begin
    logic       prev_load;
    int         hi;
    logic [7:0] word;
    int         last_start;
    bit         have_start;
    prev_load = 1'b0; hi = 0; word = 8'h00; last_start = 0; have_start = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_load = 1'b0;
        hi = 0;
      end else begin
        if (load && !prev_load) begin
          load_rises++;
          if (have_start) chk("tx_gap_ge7", 32'((cyc - last_start) >= 7), 32'd1);
          last_start = cyc;
          have_start = 1'b1;
          if (tx_exp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected_load: got word %0h want no strobe at %0t", curbyteout, $time);
          end else begin
            chk("tx_word", 32'(curbyteout), 32'(tx_exp.pop_front()));
          end
          word = curbyteout;
          hi = 1;
        end else if (load) begin
          hi++;
          chk("tx_stable", 32'(curbyteout), 32'(word));
        end
        if (load) chk("tx_busy", 32'(outsignal[0]), 32'd1);
        if (!load && prev_load) chk("load_width", 32'(hi), 32'(LOADC));
        if (rx_valid && rx_ready) begin
          if (rx_exp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_unexpected: got %0h want nothing at %0t", rx_data, $time);
          end else begin
            chk("rx_word", 32'(rx_data), 32'(rx_exp.pop_front()));
          end
        end
        prev_load = load;
      end
    end
  end

  // Global time limit.
  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    vec_t tx_vec[4];
    vec_t rx_vec[5];
    int   r0;
    int   n;
    tx_vec[0] = '{8'hA5, 8'hA5};
    tx_vec[1] = '{8'h3C, 8'h3C};
    tx_vec[2] = '{8'h00, 8'h00};
    tx_vec[3] = '{8'hFF, 8'hFF};
    rx_vec[0] = '{8'h11, 8'h11};
    rx_vec[1] = '{8'h22, 8'h22};
    rx_vec[2] = '{8'h33, 8'h33};
    rx_vec[3] = '{8'h00, 8'h00};
    rx_vec[4] = '{8'hFF, 8'hFF};

    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; rdy = 1'b0;
    instrobe = 1'b0; curbytein = 8'h00; ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_curbyteout", 32'(curbyteout), 32'd0);
    chk("rst_outsignal", 32'(outsignal), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // TX table with the peer ready.
    rdy = 1'b1;
    r0 = load_rises;
    for (int i = 0; i < 4; i++) push_tx(tx_vec[i].din, tx_vec[i].exp);
    wait_tx_idle(200, "tx_table_drain");
    chk("tx_table_count", 32'(load_rises - r0), 32'd4);

    // Peer not ready: words wait; then a mid-strobe drop lets only one go.
    rdy = 1'b0;
    repeat (4) tick();
    r0 = load_rises;
    push_tx(8'h81, 8'h81);
    push_tx(8'h42, 8'h42);
    push_tx(8'h24, 8'h24);
    repeat (20) tick();
    chk("gate_no_load", 32'(load_rises - r0), 32'd0);
    chk("gate_not_busy", 32'(outsignal[0]), 32'd0);
    chk("gate_pending", 32'(tx_exp.size()), 32'd3);
    rdy = 1'b1;
    wait_load(30, "gate_first_load");
    rdy = 1'b0;
    repeat (25) tick();
    chk("drop_one_word", 32'(load_rises - r0), 32'd1);
    chk("drop_pending", 32'(tx_exp.size()), 32'd2);
    chk("drop_idle", 32'(outsignal[0]), 32'd0);
    rdy = 1'b1;
    wait_tx_idle(200, "gate_drain");
    chk("gate_count", 32'(load_rises - r0), 32'd3);

    // Fill the TX FIFO while the peer is not ready.
    rdy = 1'b0;
    repeat (4) tick();
    r0 = load_rises;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("fill_ready_before_16", 32'(tx_ready), 32'd1);
      push_tx(8'(i * 17 + 3), 8'(i * 17 + 3));
    end
    chk("fill_ready_after_16", 32'(tx_ready), 32'd0);
    push_tx(8'hEE, 8'hEE);
    chk("fill_17th_rejected", 32'(tx_exp.size()), 32'd16);
    rdy = 1'b1;
    wait_tx_idle(400, "fill_drain");
    chk("fill_count", 32'(load_rises - r0), 32'd16);

    // RX table with the consumer ready; first word also checks latency.
    rx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        curbytein = rx_vec[i].din;
        instrobe  = 1'b1;
        rx_exp.push_back(rx_vec[i].exp);
        n = 0;
        while (rx_valid !== 1'b1 && n < 20) begin
          tick();
          n++;
        end
        chk("rx_latency", 32'(n), 32'(SYNC + 2));
        instrobe = 1'b0;
        repeat (4) tick();
      end else begin
        send_rx(rx_vec[i].din, 1'b1, 1'b0);
      end
    end
    wait_rx_empty(50, "rx_table_drain");

    // RX overflow: 16 stored, 17th dropped, set beats a simultaneous clear.
    rx_ready = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 16; i++) send_rx(8'(8'h40 + i), 1'b1, 1'b0);
    chk("ovf_clear_at_16", 32'(outsignal[1]), 32'd0);
    send_rx(8'hD1, 1'b0, 1'b0);
    chk("ovf_set", 32'(outsignal[1]), 32'd1);
    chk("ovf_rx_valid", 32'(rx_valid), 32'd1);
    send_rx(8'hD2, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(outsignal[1]), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tick();
    chk("ovf_lone_clear", 32'(outsignal[1]), 32'd0);
    rx_ready = 1'b1;
    wait_rx_empty(60, "ovf_drain");
    repeat (2) tick();
    chk("ovf_drained", 32'(rx_valid), 32'd0);

    // Reset during STROBE with data held in both FIFOs.
    rx_ready = 1'b0;
    send_rx(8'h5E, 1'b1, 1'b0);
    chk("rst_pre_rx_valid", 32'(rx_valid), 32'd1);
    rdy = 1'b1;
    push_tx(8'h77, 8'h77);
    push_tx(8'h88, 8'h88);
    wait_load(30, "rst_wait_strobe");
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_load", 32'(load), 32'd0);
    chk("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_mid_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_mid_outsignal", 32'(outsignal), 32'd0);
    tx_exp.delete();
    rx_exp.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    r0 = load_rises;
    repeat (20) tick();
    chk("post_rst_idle", 32'(outsignal[0]), 32'd0);
    chk("post_rst_no_load", 32'(load_rises - r0), 32'd0);
    chk("post_rst_rx_empty", 32'(rx_valid), 32'd0);
    chk("post_rst_tx_ready", 32'(tx_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
